cond_exec_stage: RTL and testbench
==================================

# cond_exec_stage

Conditional-execution stage for the ARM-style pipeline, sitting at the ID/EXE boundary as the reader of the NZCV status register. It captures a decoded instruction's 4-bit condition field and evaluates it against the current flags, with same-cycle forwarding from a flag-setting instruction in EXE. It drives the EXE-stage execute enable and the status-register load enable for the instruction it holds. One-entry pipeline register with stall and flush.

## Interface
Parameters:
- FLAG_W, 4, flag vector width, fixed order {N,Z,C,V} (bit 3 = N, bit 0 = V).
- CNT_W, 16, width of the statistics counters (COND_STATS_EN only).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  decoded instruction is presented this cycle.
- in_cond  input  4  ARM condition field.
- in_s  input  1  instruction requests a flag update (S bit).
- stall  input  1  hold the stage contents.
- flush  input  1  discard the stage contents (branch taken).
- sr_flags  input  4  current status register output.
- fwd_flags  input  4  ALU flags of the instruction now in EXE.
- fwd_valid  input  1  instruction in EXE executes and writes flags.
- out_valid  output  1  stage holds an instruction.
- out_exec  output  1  held instruction passes its condition.
- out_sr_ld  output  1  status register load enable: out_exec & held S bit.
- out_cond  output  4  held condition field (debug/trace).
- fail_count  output  CNT_W  retired condition-fail count (COND_STATS_EN only).
- exec_count  output  CNT_W  retired condition-pass count (COND_STATS_EN only).

## Operation
- States: EMPTY and FULL, encoded by out_valid.
- Effective flags: fwd_flags when fwd_valid=1, otherwise sr_flags.
- Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0 (never executes).
- Next-state priority is flush, then stall, then capture:
  - flush=1: go to EMPTY regardless of stall or in_valid.
  - stall=1 with FULL: cond and S are held, and the pass bit is re-evaluated every cycle against the current effective flags.
  - Otherwise: capture in_valid, in_cond and in_s. The pass bit is evaluated from in_cond and the effective flags in the same cycle.
- out_exec and out_sr_ld are forced to 0 whenever the stage is EMPTY.
- An instruction retires on any cycle with FULL, !stall and !flush.

## Timing
- Latency: one cycle from in_valid to out_valid/out_exec.
- Reset values: out_valid=0, out_exec=0, out_sr_ld=0, out_cond=0, counters=0. Reset is asynchronous and takes effect mid-stall as well.
- The status register loads on the falling edge. Forwarding covers a flag writer that is in EXE during the same cycle the dependent instruction is captured.
- Back-to-back S instructions: each is evaluated against its predecessor's forwarded flags.
- When stall=1 and EMPTY, the stage remains EMPTY and in_valid is ignored.

## Configuration
- COND_STATS_EN defined:
  - fail_count increments on each retirement with pass=0; exec_count increments on each retirement with pass=1.
  - Both counters saturate at all-ones and are cleared only by rst.
  - Flushed or stalled cycles are not counted.
- COND_STATS_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Package cond_pkg holds:
  - the cond_e enum for the 16 codes;
  - flag index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0;
  - the FLAG_W constant.
- Sub-module cond_eval is combinational: (cond, flags) -> pass. It is instantiated once, fed by a mux between in_cond and the held cond.

## Test plan
- Reset mid-FULL (stage holding AL with S=1): assert rst -> out_valid, out_exec, out_sr_ld are 0 immediately, before the next edge.
- Condition sweep: sr_flags=4'b0100 (Z=1), fwd_valid=0, in_cond 0..F one per cycle -> out_exec pattern EQ=1, NE=0, HI=0, LS=1, GE=1, GT=0, LE=1, AL=1, NV=0.
- Forwarding: sr_flags=0000, fwd_valid=1 with fwd_flags=0100, in_cond=EQ -> out_exec=1. The same inputs with fwd_valid=0 -> out_exec=0.
- Stall re-evaluation: capture GT with flags 0000 (pass), then stall 2 cycles with sr_flags changed to 0100 -> out_exec drops to 0 and out_cond stays C.
- Flush priority: FULL, flush=1, stall=1, in_valid=1 -> EMPTY next cycle and out_sr_ld=0.
- COND_STATS_EN: retire 3 NV and 2 AL instructions plus one flushed AL -> fail_count=3, exec_count=2. Preloading to all-ones shows saturation.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage.
// Holds the ARM condition-code enum, the {N,Z,C,V} bit positions and the flag width.
// No ports; imported by cond_eval and cond_exec_stage.
package cond_pkg;

  localparam int FLAG_W = 4;

  // Flag vector order is {N,Z,C,V}
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Condition evaluator: decides whether an ARM condition code passes for a flag vector.
// Latency: purely combinational, zero cycles. No backpressure.
// Ports: i_cond (condition code), i_flags ({N,Z,C,V}), o_pass (1 = condition holds).
module cond_eval
  import cond_pkg::*;
(
  input  cond_e             i_cond,
  input  logic [FLAG_W-1:0] i_flags,
  output logic              o_pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[N_BIT];
  assign w_z = i_flags[Z_BIT];
  assign w_c = i_flags[C_BIT];
  assign w_v = i_flags[V_BIT];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Conditional-execution stage at ID/EXE: holds one instruction and its condition-pass bit.
// Latency: one cycle from in_valid to out_valid/out_exec; flags forwarded from EXE same cycle.
// Backpressure: stall holds the entry (pass re-evaluated each cycle), flush empties it and wins.
// Ports: clk/rst (async, active-high); in_valid/in_cond/in_s decoded instruction; stall, flush;
//   sr_flags (status register), fwd_flags/fwd_valid (EXE forwarding); out_valid, out_exec,
//   out_sr_ld, out_cond. With COND_STATS_EN defined: fail_count, exec_count retirement counters.
module cond_exec_stage #(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic              stall,
  input  logic              flush,
  input  logic [FLAG_W-1:0] sr_flags,
  input  logic [FLAG_W-1:0] fwd_flags,
  input  logic              fwd_valid,
  output logic              out_valid,
  output logic              out_exec,
  output logic              out_sr_ld,
  output logic [3:0]        out_cond
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0]  fail_count,
  output logic [CNT_W-1:0]  exec_count
`endif
);

  import cond_pkg::*;

  // r_valid is the EMPTY/FULL state bit
  logic              r_valid;
  cond_e             r_cond;
  logic              r_s;
  logic              r_pass;

  logic [FLAG_W-1:0] w_eff_flags;
  cond_e             w_cond_sel;
  logic              w_pass;
  logic              w_hold;

  assign w_eff_flags = fwd_valid ? fwd_flags : sr_flags;

  // A stalled FULL entry re-evaluates its own cond; otherwise the incoming cond is evaluated
  assign w_hold      = stall & r_valid;
  assign w_cond_sel  = w_hold ? r_cond : cond_e'(in_cond);

  cond_eval u_cond_eval (
    .i_cond  (w_cond_sel),
    .i_flags (w_eff_flags),
    .o_pass  (w_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_cond  <= COND_EQ;
      r_s     <= 1'b0;
      r_pass  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
    end else if (stall) begin
      // Stalled while EMPTY: stay EMPTY and ignore in_valid
      if (r_valid) begin
        r_pass <= w_pass;
      end
    end else begin
      r_valid <= in_valid;
      r_cond  <= cond_e'(in_cond);
      r_s     <= in_s;
      r_pass  <= w_pass;
    end
  end

  assign out_valid = r_valid;
  assign out_exec  = r_valid & r_pass;
  assign out_sr_ld = r_valid & r_pass & r_s;
  assign out_cond  = r_cond;

`ifdef COND_STATS_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_exec_cnt;

  assign w_retire = r_valid & ~stall & ~flush;

  // Saturating counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_cnt <= '0;
      r_exec_cnt <= '0;
    end else if (w_retire) begin
      if (r_pass) begin
        if (r_exec_cnt != '1) r_exec_cnt <= r_exec_cnt + 1'b1;
      end else begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
      end
    end
  end

  assign fail_count = r_fail_cnt;
  assign exec_count = r_exec_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: vector table, directed corner cases, random vs model.
// Latency: outputs checked 1 time unit after the rising edge that captured the inputs.
// Backpressure: stall/flush exercised directly and randomly.
module tb_cond_exec_stage;

  localparam int TB_CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_cond;
  logic       in_s;
  logic       stall;
  logic       flush;
  logic [3:0] sr_flags;
  logic [3:0] fwd_flags;
  logic       fwd_valid;
  logic       out_valid;
  logic       out_exec;
  logic       out_sr_ld;
  logic [3:0] out_cond;
`ifdef COND_STATS_EN
  logic [TB_CNT_W-1:0] fail_count;
  logic [TB_CNT_W-1:0] exec_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cond_exec_stage #(.FLAG_W(4), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_cond   (in_cond),
    .in_s      (in_s),
    .stall     (stall),
    .flush     (flush),
    .sr_flags  (sr_flags),
    .fwd_flags (fwd_flags),
    .fwd_valid (fwd_valid),
    .out_valid (out_valid),
    .out_exec  (out_exec),
    .out_sr_ld (out_sr_ld),
    .out_cond  (out_cond)
`ifdef COND_STATS_EN
    ,
    .fail_count(fail_count),
    .exec_count(exec_count)
`endif
  );

  typedef struct {
    logic [3:0] cond;
    logic [3:0] sr;
    logic [3:0] fwd;
    logic       fwd_v;
    logic       s;
    logic       exp_exec;
    logic       exp_srld;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: even codes test a predicate, odd codes its inverse; E always, F never
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_cond = 0; in_s = 0; stall = 0; flush = 0;
    sr_flags = 0; fwd_flags = 0; fwd_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #3;
    rst = 0;
    #1;
  endtask

  logic [15:0] sweep_exp;
  logic        m_valid, m_s, m_pass;
  logic [3:0]  m_cond;
  logic [3:0]  eff;

  initial begin
    rst = 1;
    idle_inputs();

    // Vector table: Z=1 sweep over all 16 codes, then forwarding cases
    sweep_exp = 16'b0110_0110_1010_1001;
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{cond: 4'(i), sr: 4'b0100, fwd: 4'b0000, fwd_v: 1'b0, s: 1'b1,
                  exp_exec: sweep_exp[i], exp_srld: sweep_exp[i]};
    end
    vecs[16] = '{cond: 4'h0, sr: 4'b0000, fwd: 4'b0100, fwd_v: 1'b1, s: 1'b0, exp_exec: 1'b1, exp_srld: 1'b0};
    vecs[17] = '{cond: 4'h0, sr: 4'b0000, fwd: 4'b0100, fwd_v: 1'b0, s: 1'b1, exp_exec: 1'b0, exp_srld: 1'b0};
    vecs[18] = '{cond: 4'hA, sr: 4'b1001, fwd: 4'b0000, fwd_v: 1'b0, s: 1'b1, exp_exec: 1'b1, exp_srld: 1'b1};
    vecs[19] = '{cond: 4'hB, sr: 4'b1001, fwd: 4'b1000, fwd_v: 1'b1, s: 1'b0, exp_exec: 1'b1, exp_srld: 1'b0};

    // Reset state
    #1;
    check("reset_valid", 8'(out_valid), 8'd0);
    check("reset_exec",  8'(out_exec),  8'd0);
    check("reset_srld",  8'(out_sr_ld), 8'd0);
    check("reset_cond",  8'(out_cond),  8'd0);
    @(negedge clk);
    rst = 0;
    tick();

    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_cond = vecs[i].cond; in_s = vecs[i].s;
      sr_flags = vecs[i].sr; fwd_flags = vecs[i].fwd; fwd_valid = vecs[i].fwd_v;
      tick();
      check($sformatf("vec%0d_valid", i), 8'(out_valid), 8'd1);
      check($sformatf("vec%0d_exec", i),  8'(out_exec),  8'(vecs[i].exp_exec));
      check($sformatf("vec%0d_srld", i),  8'(out_sr_ld), 8'(vecs[i].exp_srld));
      check($sformatf("vec%0d_cond", i),  8'(out_cond),  8'(vecs[i].cond));
    end

    // Stall re-evaluation: GT passes on 0000, fails once Z appears while stalled
    idle_inputs();
    in_valid = 1; in_cond = 4'hC;
    tick();
    check("stall_gt_capture", 8'(out_exec), 8'd1);
    in_valid = 0; stall = 1; sr_flags = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_gt_exec",  8'(out_exec),  8'd0);
      check("stall_gt_valid", 8'(out_valid), 8'd1);
      check("stall_gt_cond",  8'(out_cond),  8'hC);
    end

    // Flush beats stall and capture
    idle_inputs();
    in_valid = 1; in_cond = 4'hE; in_s = 1;
    tick();
    check("flush_pre_srld", 8'(out_sr_ld), 8'd1);
    flush = 1; stall = 1;
    tick();
    check("flush_valid", 8'(out_valid), 8'd0);
    check("flush_srld",  8'(out_sr_ld), 8'd0);
    check("flush_exec",  8'(out_exec),  8'd0);

    // Stall while EMPTY ignores in_valid
    flush = 0; stall = 1; in_valid = 1;
    tick();
    check("stall_empty_valid", 8'(out_valid), 8'd0);

    // Asynchronous reset while FULL and stalled
    idle_inputs();
    in_valid = 1; in_cond = 4'hE; in_s = 1;
    tick();
    check("prereset_srld", 8'(out_sr_ld), 8'd1);
    stall = 1;
    #1;
    rst = 1;
    #1;
    check("async_rst_valid", 8'(out_valid), 8'd0);
    check("async_rst_exec",  8'(out_exec),  8'd0);
    check("async_rst_srld",  8'(out_sr_ld), 8'd0);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    tick();

    // Random stimulus against the reference model
    m_valid = 0; m_s = 0; m_pass = 0; m_cond = 0;
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_cond   = 4'($urandom_range(0, 15));
      in_s      = 1'($urandom_range(0, 1));
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      sr_flags  = 4'($urandom_range(0, 15));
      fwd_flags = 4'($urandom_range(0, 15));
      fwd_valid = 1'($urandom_range(0, 1));
      eff = fwd_valid ? fwd_flags : sr_flags;
      if (flush) begin
        m_valid = 0;
      end else if (stall) begin
        if (m_valid) m_pass = ref_pass(m_cond, eff);
      end else begin
        m_valid = in_valid; m_cond = in_cond; m_s = in_s;
        m_pass  = ref_pass(in_cond, eff);
      end
      tick();
      check("rand_valid", 8'(out_valid), 8'(m_valid));
      check("rand_exec",  8'(out_exec),  8'(m_valid & m_pass));
      check("rand_srld",  8'(out_sr_ld), 8'(m_valid & m_pass & m_s));
      if (m_valid) check("rand_cond", 8'(out_cond), 8'(m_cond));
    end

`ifdef COND_STATS_EN
    // Counters: 3 NV + 2 AL retired, one AL flushed
    idle_inputs();
    do_reset();
    check("cnt_reset_fail", 8'(fail_count), 8'd0);
    check("cnt_reset_exec", 8'(exec_count), 8'd0);
    in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      in_cond = (k < 3) ? 4'hF : 4'hE;
      tick();
    end
    in_valid = 0; flush = 1;
    tick();
    flush = 0;
    tick();
    check("cnt_fail", 8'(fail_count), 8'd3);
    check("cnt_exec", 8'(exec_count), 8'd2);
    // Push the fail counter past its maximum
    in_valid = 1; in_cond = 4'hF;
    for (int k = 0; k < 6; k++) tick();
    in_valid = 0;
    tick();
    tick();
    check("cnt_fail_sat", 8'(fail_count), 8'd7);
    check("cnt_exec_hold", 8'(exec_count), 8'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
